// File: rtl/tlc_pkg.sv
// Shared types and constants for the intersection lamp controllers.
// Lamp codes, approach indices and the demand-scheduler state encoding.
package tlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] S = 2'd2;
  localparam logic [1:0] W = 2'd3;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } tlc_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational 4-way round-robin picker: first set bit of pending searching
// cur+1, cur+2, cur+3, cur (mod 4). winner holds cur when nothing is pending.
module tlc_rr_pick (
  input  logic [3:0] pending,
  input  logic [1:0] cur,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  assign any = |pending;

  always_comb begin
    winner = cur;
    found  = 1'b0;
    idx    = cur;
    for (int k = 1; k <= 4; k++) begin
      idx = cur + 2'(k);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_demand_scheduler.sv
// Demand-actuated four-approach lamp scheduler: latched requests served round-robin,
// green extended by detector presence between min and max, then yellow and all-red.
module tlc_demand_scheduler
  import tlc_pkg::*;
#(
  parameter int TG_MIN = 4,
  parameter int TG_MAX = 12,
  parameter int TY     = 3,
  parameter int TAR    = 1,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [2:0] north,
  output logic [2:0] east,
  output logic [2:0] south,
  output logic [2:0] west,
  output logic [1:0] grant,
  output logic       green_start
);

  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] TG_MIN_C = CW'(TG_MIN);
  localparam logic [CW-1:0] TG_MAX_C = CW'(TG_MAX);
  localparam logic [CW-1:0] TY_C     = CW'(TY);
  localparam logic [CW-1:0] TAR_C    = CW'(TAR);

  tlc_state_t    state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    pending_q, pending_d;

  logic [1:0] winner;
  logic       any_pend;
  logic [3:0] cur_oh;
  logic       other;
  logic       gap_out;
  logic       max_out;
  logic [3:0] req_mask;

  tlc_rr_pick u_pick (
    .pending (pending_q),
    .cur     (cur_q),
    .winner  (winner),
    .any     (any_pend)
  );

  assign cur_oh  = onehot4(cur_q);
  assign other   = |(pending_q & ~cur_oh);
  assign gap_out = (count_q >= TG_MIN_C) && !req[cur_q];
  assign max_out = (count_q >= TG_MAX_C);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    count_d   = count_q;
    // The served approach's own detector only extends green; it is not a new demand.
    req_mask  = (state_q == GREEN) ? ~cur_oh : 4'hF;
    pending_d = pending_q | (req & req_mask);

    unique case (state_q)
      ALLRED: begin
        if (count_q >= TAR_C && any_pend) begin
          state_d           = GREEN;
          cur_d             = winner;
          count_d           = ONE_C;
          pending_d[winner] = 1'b0;
        end else if (count_q < TAR_C) begin
          count_d = count_q + ONE_C;
        end
      end
      GREEN: begin
        if (other && (gap_out || max_out)) begin
          state_d = YELLOW;
          count_d = ONE_C;
        end else if (count_q < TG_MAX_C) begin
          count_d = count_q + ONE_C;
        end
      end
      YELLOW: begin
        if (count_q == TY_C) begin
          state_d = ALLRED;
          count_d = ONE_C;
        end else begin
          count_d = count_q + ONE_C;
        end
      end
      default: begin
        state_d = ALLRED;
        count_d = ONE_C;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ALLRED;
      cur_q     <= 2'd0;
      count_q   <= ONE_C;
      pending_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  logic [2:0] lamp [4];

  always_comb begin
    for (int i = 0; i < 4; i++) lamp[i] = LAMP_RED;
    if (state_q == GREEN)       lamp[cur_q] = LAMP_GRN;
    else if (state_q == YELLOW) lamp[cur_q] = LAMP_YEL;
  end

  assign north       = lamp[N];
  assign east        = lamp[E];
  assign south       = lamp[S];
  assign west        = lamp[W];
  assign grant       = cur_q;
  assign green_start = (state_q == GREEN) && (count_q == ONE_C);

  logic [3:0] non_red;
  assign non_red = {west != LAMP_RED, south != LAMP_RED, east != LAMP_RED, north != LAMP_RED};

  a_one_lamp: assert property (@(posedge clk) disable iff (rst) $onehot0(non_red));
  a_yel_len:  assert property (@(posedge clk) disable iff (rst)
                               (state_q == YELLOW) |-> (count_q <= TY_C));

endmodule

// File: doc/tlc_demand_scheduler.md
# tlc_demand_scheduler

Demand-actuated scheduler for the four-approach intersection lamps. It sequences green, yellow and all-red phases. Each green goes to the approaches that have latched vehicle demand, served in round-robin order. Green time is extended while the served approach still detects traffic, bounded by minimum and maximum green. It drives the same north/east/south/west 3-bit lamp buses as the fixed-time controller and replaces it where loop detectors are fitted.

## Interface
- `TG_MIN`, 4: minimum green cycles.
- `TG_MAX`, 12: maximum green cycles when another approach is waiting.
- `TY`, 3: yellow cycles.
- `TAR`, 1: minimum all-red clearance cycles.
- `CW`, 4: phase counter width. Legal ranges: TAR≥1, TY≥1, 1≤TG_MIN≤TG_MAX≤2^CW−1.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: vehicle presence per approach; bit 0=N, 1=E, 2=S, 3=W.
- `north`, `east`, `south`, `west` out 3 each: lamp code, 100 red, 010 yellow, 001 green.
- `grant` out 2: index of current/last served approach.
- `green_start` out 1: one-cycle pulse on the first cycle of every GREEN.

## Operation
- Registers:
  - `state` ∈ {ALLRED, GREEN, YELLOW}
  - `cur[1:0]`
  - `count[CW-1:0]`
  - `pending[3:0]`
- Reset: state=ALLRED, count=1, cur=0, pending=0. All lamps 100, grant=0, green_start=0.
- count is 1 on the first cycle of each state and increments every cycle. It saturates at TAR in ALLRED and at TG_MAX in GREEN.
- pending[i] is set when req[i]=1. Exceptions:
  - req[cur] is ignored while state=GREEN.
  - pending[winner] is cleared on the transition into GREEN; this clear beats a simultaneous set.
- ALLRED → GREEN when count≥TAR and pending≠0.
  - winner = first set bit of pending, searching cur+1, cur+2, cur+3, cur (mod 4).
  - On this transition: cur←winner, count←1.
  - With pending=0 the block stays in ALLRED indefinitely (red rest).
- GREEN → YELLOW when other=|(pending & ~onehot(cur)) is 1 and either:
  - gap-out: count≥TG_MIN and req[cur]=0, or
  - max-out: count≥TG_MAX.
  - With other=0 the block rests in GREEN indefinitely.
- YELLOW → ALLRED when count==TY.
- Lamp decode is purely from `state`/`cur`:
  - approach cur shows 001 in GREEN, 010 in YELLOW.
  - every other lamp, and all lamps in ALLRED, show 100.
- Safety invariant: at most one lamp is non-red in any cycle.
- grant=cur. green_start=(state==GREEN && count==1).

## Timing
- Outputs are decoded from registered state; there are no extra output flops.
- Dwell per state:
  - GREEN lasts between TG_MIN and TG_MAX cycles when contested.
  - YELLOW lasts exactly TY cycles.
  - ALLRED lasts at least TAR cycles.
- Request latency while resting in ALLRED with count saturated:
  - req sampled high at edge k sets pending at edge k;
  - GREEN is entered at edge k+1.
- A one-cycle req pulse is never lost; it stays pending until served.
- req on the current approach during YELLOW/ALLRED latches pending[cur]. That approach is served again only after all other pending approaches.
- Reset asserted in any state: on the next edge, state, counters and pending take reset values, and all lamps read 100 that cycle.

## Structure
- Shared package `tlc_pkg` holds:
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001;
  - approach indices N=0, E=1, S=2, W=3;
  - state encoding type tlc_state_t (ALLRED, GREEN, YELLOW).
- Sub-module `tlc_rr_pick` is a combinational 4-way round-robin picker: inputs pending[3:0] and cur[1:0]; outputs winner[1:0] and any.
- Top level holds the FSM, counter, pending register and lamp decode.

## Test plan
- Reset: rst=1 for 2 cycles, then req=0 for 20 cycles → all lamps 100, grant=0, green_start never pulses.
- Single request: 1-cycle req[1] pulse while resting → east=001 two edges later with green_start=1 for one cycle. East rests green for 50 cycles; other lamps stay 100.
- Gap-out: east green, req[1]=0, req[3] pulsed at green count 2 → east 001 for exactly 4 cycles, 010 for 3, all 100 for 1, then west=001.
- Max-out: east green with req[1] held high and req[2] pending → east 001 for exactly 12 cycles, then yellow; south greens after 3 yellow + 1 all-red cycles.
- Round-robin: cur=E, pending={N,S,W} set simultaneously, req then low → greens served in order S, W, N. The one-hot lamp invariant is checked every cycle.
- Reset mid-phase: rst asserted on the 2nd YELLOW cycle with pending={N} → next cycle all lamps 100, pending=0, no green follows without new req.
